// File: rtl/dip_led_ctrl.sv
// LED owner for the trainer board: debounced DIP mirror, host req/gnt
// override and a timed blinking flash whenever a DIP switch changes.
module dip_led_ctrl #(
  parameter int unsigned DEB_CYCLES   = 500000,
  parameter int unsigned HOLD_CYCLES  = 25000000,
  parameter int unsigned BLINK_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] trainer_dip,
  input  logic       host_req,
  input  logic [7:0] host_led,
  output logic       host_gnt,
  output logic [7:0] led,
  output logic [7:0] dip_stable,
  output logic       dip_changed
);

  localparam int unsigned DW = $clog2(DEB_CYCLES);
  localparam int unsigned HW = $clog2(HOLD_CYCLES);
  localparam int unsigned BW = $clog2(BLINK_CYCLES);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  // Hold counts HOLD_CYCLES-1 down to 0 so the count fits in $clog2 bits.
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {S_DIP, S_HOST, S_EVENT} state_e;

  state_e        state_q;
  logic [7:0]    sync1_q, sync_q, dip_stable_q, mask_q, led_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0] hold_q;
  logic [BW-1:0] blink_cnt_q;
  logic          primed_q, dip_changed_q, gnt_q, phase_q;
  logic          commit, evt, blink_wrap, phase_d;
  logic [7:0]    change, mask_d;

  always_comb begin
    change    = sync_q ^ dip_stable_q;
    commit    = 1'b0;
    deb_cnt_d = deb_cnt_q + DW'(1);
    // sync1_q != sync_q means sync_q changes on this edge: restart counting.
    if (sync_q == dip_stable_q || sync1_q != sync_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      commit    = 1'b1;
      deb_cnt_d = '0;
    end
    evt        = commit & primed_q;
    blink_wrap = (blink_cnt_q == BLINK_LAST);
    phase_d    = phase_q ^ blink_wrap;
    mask_d     = evt ? (mask_q | change) : mask_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync_q        <= '0;
      dip_stable_q  <= '0;
      deb_cnt_q     <= '0;
      primed_q      <= 1'b0;
      dip_changed_q <= 1'b0;
    end else begin
      sync1_q       <= trainer_dip;
      sync_q        <= sync1_q;
      deb_cnt_q     <= deb_cnt_d;
      dip_changed_q <= evt;
      if (commit) begin
        dip_stable_q <= sync_q;
        primed_q     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_DIP;
      gnt_q       <= 1'b0;
      led_q       <= '0;
      mask_q      <= '0;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      case (state_q)
        S_DIP, S_HOST: begin
          if (evt) begin
            state_q     <= S_EVENT;
            gnt_q       <= 1'b0;
            mask_q      <= change;
            hold_q      <= HOLD_LAST;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            led_q       <= change;
          end else if (host_req) begin
            state_q <= S_HOST;
            gnt_q   <= 1'b1;
            led_q   <= host_led;
          end else begin
            state_q <= S_DIP;
            gnt_q   <= 1'b0;
            led_q   <= dip_stable_q;
          end
        end
        S_EVENT: begin
          if (!evt && hold_q == '0) begin
            mask_q      <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            if (host_req) begin
              state_q <= S_HOST;
              gnt_q   <= 1'b1;
              led_q   <= host_led;
            end else begin
              state_q <= S_DIP;
              gnt_q   <= 1'b0;
              led_q   <= dip_stable_q;
            end
          end else begin
            // A merged event widens the mask and restarts the hold, blink runs on.
            hold_q      <= evt ? HOLD_LAST : hold_q - HW'(1);
            mask_q      <= mask_d;
            blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + BW'(1);
            phase_q     <= phase_d;
            led_q       <= phase_d ? mask_d : '0;
          end
        end
        default: begin
          state_q <= S_DIP;
          gnt_q   <= 1'b0;
          led_q   <= '0;
        end
      endcase
    end
  end

  assign host_gnt    = gnt_q;
  assign led         = led_q;
  assign dip_stable  = dip_stable_q;
  assign dip_changed = dip_changed_q;

endmodule
